// File: rtl/apb_uart_fifo_if.sv
// APB bus bundle between a master and the apb_uart_fifo slave.
interface apb_uart_fifo_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_uart_fifo.sv
// APB-slave UART with TX/RX FIFOs, programmable divisor, parity and sticky errors.
// Optional feature macro: UART_LOOPBACK_EN (CTRL[4] internal loopback).
module apb_uart_fifo #(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    apb_uart_fifo_if.slave apb,
    input  logic           uart_rx,
    output logic           uart_tx,
    output logic           irq
);
    localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    function automatic logic par_bit(input logic [DATA_BITS-1:0] d, input logic odd);
        return odd ? ~(^d) : (^d);
    endfunction

    logic                 access_s, wr_s, rd_s, addr_bad_s;
    logic [2:0]           reg_s, clr_s;
    logic                 tx_push_s, tx_pop_s, rx_pop_s, rx_wr_s;
    logic                 tx_full_s, tx_empty_s, rx_full_s, rx_empty_s, tx_busy_s;
    logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]        tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]        tx_cnt_q, rx_cnt_q;
    logic [3:0]           ctrl_q;
    logic [15:0]          div_q, div_eff_s, rx_half_s;
    logic [2:0]           irq_en_q;
    logic                 perr_q, ferr_q, ovr_q, irq_q;
    logic                 lb_rd_s, rx_src_s;
    logic [31:0]          rdata_s;
    logic                 unused_s;

    state_e               tx_state_q;
    logic [15:0]          tx_tmr_q, tx_div_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic [2:0]           tx_bit_q;
    logic                 tx_pon_q, tx_pbit_q, tx_line_q;

    state_e               rx_state_q;
    logic [15:0]          rx_tmr_q, rx_div_q;
    logic [DATA_BITS-1:0] rx_shift_q, rx_char_q;
    logic [2:0]           rx_bit_q;
    logic                 rx_pon_q, rx_podd_q, rx_pbit_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q, rx_push_q, rx_perr_q, rx_ferr_q;

    assign unused_s   = ^{apb.PWDATA[31:16], apb.PADDR[1:0]};
    assign access_s   = apb.PSEL & apb.PENABLE;
    assign wr_s       = access_s & apb.PWRITE;
    assign rd_s       = access_s & ~apb.PWRITE;
    assign addr_bad_s = apb.PADDR > 5'h10;
    assign reg_s      = apb.PADDR[4:2];

    assign tx_full_s  = tx_cnt_q == FULL_CNT;
    assign tx_empty_s = tx_cnt_q == CW'(0);
    assign rx_full_s  = rx_cnt_q == FULL_CNT;
    assign rx_empty_s = rx_cnt_q == CW'(0);
    assign tx_busy_s  = tx_state_q != S_IDLE;

    assign tx_push_s = wr_s & ~addr_bad_s & (reg_s == 3'd0) & ~tx_full_s;
    assign rx_pop_s  = rd_s & ~addr_bad_s & (reg_s == 3'd0) & ~rx_empty_s;
    assign rx_wr_s   = rx_push_q & ~rx_full_s;
    assign clr_s     = (wr_s & ~addr_bad_s & (reg_s == 3'd1)) ? apb.PWDATA[7:5] : 3'b000;
    // A new frame may start from IDLE or straight out of the last STOP cycle.
    assign tx_pop_s  = ctrl_q[0] & ~tx_empty_s &
                       ((tx_state_q == S_IDLE) | ((tx_state_q == S_STOP) & (tx_tmr_q == 16'd0)));

    assign div_eff_s = (div_q < 16'd3) ? 16'd3 : div_q;
    assign rx_half_s = (div_eff_s - 16'd1) >> 1;

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access_s & (addr_bad_s | (wr_s & (reg_s == 3'd0) & tx_full_s));
    assign apb.PRDATA  = rdata_s;
    assign irq         = irq_q;

`ifdef UART_LOOPBACK_EN
    logic lb_q;

    // Loopback enable bit (CTRL[4]).
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lb_q <= 1'b0;
        end else if (wr_s && !addr_bad_s && reg_s == 3'd2) begin
            lb_q <= apb.PWDATA[4];
        end else begin
            lb_q <= lb_q;
        end
    end

    assign lb_rd_s  = lb_q;
    assign rx_src_s = lb_q ? tx_line_q : uart_rx;
    assign uart_tx  = lb_q ? 1'b1 : tx_line_q;
`else
    assign lb_rd_s  = 1'b0;
    assign rx_src_s = uart_rx;
    assign uart_tx  = tx_line_q;
`endif

    // Read mux: only drives data during a read access phase.
    always_comb begin
        rdata_s = 32'd0;
        if (rd_s && !addr_bad_s) begin
            case (reg_s)
                3'd0: begin
                    if (!rx_empty_s) rdata_s[DATA_BITS-1:0] = rx_mem_q[rx_rp_q];
                    else             rdata_s = 32'd0;
                end
                3'd1:    rdata_s = {24'd0, ovr_q, ferr_q, perr_q, tx_busy_s,
                                    rx_empty_s, rx_full_s, tx_empty_s, tx_full_s};
                3'd2:    rdata_s = {27'd0, lb_rd_s, ctrl_q};
                3'd3:    rdata_s = {16'd0, div_q};
                3'd4:    rdata_s = {29'd0, irq_en_q};
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Control registers, sticky error flags (set wins over clear) and irq.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q   <= 4'h3;
            div_q    <= DIV_RESET;
            irq_en_q <= 3'd0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_s && !addr_bad_s) begin
                case (reg_s)
                    3'd2:    ctrl_q   <= apb.PWDATA[3:0];
                    3'd3:    div_q    <= apb.PWDATA[15:0];
                    3'd4:    irq_en_q <= apb.PWDATA[2:0];
                    default: ctrl_q   <= ctrl_q;
                endcase
            end
            perr_q <= (perr_q & ~clr_s[0]) | rx_perr_q;
            ferr_q <= (ferr_q & ~clr_s[1]) | rx_ferr_q;
            ovr_q  <= (ovr_q  & ~clr_s[2]) | (rx_push_q & rx_full_s);
            irq_q  <= |(irq_en_q & {perr_q | ferr_q | ovr_q, ~rx_empty_s, tx_empty_s});
        end
    end

    // FIFO storage (no reset needed; validity is tracked by the counts).
    always_ff @(posedge PCLK) begin
        if (tx_push_s) tx_mem_q[tx_wp_q] <= apb.PWDATA[DATA_BITS-1:0];
        if (rx_wr_s)   rx_mem_q[rx_wp_q] <= rx_char_q;
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
            rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
        end else begin
            if (tx_push_s) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop_s)  tx_rp_q <= tx_rp_q + AW'(1);
            if (rx_wr_s)   rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop_s)  rx_rp_q <= rx_rp_q + AW'(1);
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_cnt_q <= tx_cnt_q + CW'(1);
                2'b01:   tx_cnt_q <= tx_cnt_q - CW'(1);
                default: tx_cnt_q <= tx_cnt_q;
            endcase
            case ({rx_wr_s, rx_pop_s})
                2'b10:   rx_cnt_q <= rx_cnt_q + CW'(1);
                2'b01:   rx_cnt_q <= rx_cnt_q - CW'(1);
                default: rx_cnt_q <= rx_cnt_q;
            endcase
        end
    end

    // TX FSM; divisor and parity mode are captured when a frame starts.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state_q <= S_IDLE;
            tx_tmr_q   <= 16'd0;
            tx_div_q   <= 16'd0;
            tx_shift_q <= '0;
            tx_bit_q   <= 3'd0;
            tx_pon_q   <= 1'b0;
            tx_pbit_q  <= 1'b0;
            tx_line_q  <= 1'b1;
        end else if (tx_pop_s) begin
            tx_state_q <= S_START;
            tx_tmr_q   <= div_eff_s;
            tx_div_q   <= div_eff_s;
            tx_shift_q <= tx_mem_q[tx_rp_q];
            tx_pon_q   <= ^ctrl_q[3:2];
            tx_pbit_q  <= par_bit(tx_mem_q[tx_rp_q], ctrl_q[3:2] == 2'b01);
            tx_line_q  <= 1'b0;
        end else if (tx_state_q == S_IDLE) begin
            tx_line_q <= 1'b1;
        end else if (tx_tmr_q != 16'd0) begin
            tx_tmr_q <= tx_tmr_q - 16'd1;
        end else begin
            tx_tmr_q <= tx_div_q;
            case (tx_state_q)
                S_START: begin
                    tx_state_q <= S_DATA;
                    tx_bit_q   <= 3'd0;
                    tx_line_q  <= tx_shift_q[0];
                end
                S_DATA: begin
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_q <= tx_pon_q ? S_PARITY : S_STOP;
                        tx_line_q  <= tx_pon_q ? tx_pbit_q : 1'b1;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 3'd1;
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_line_q  <= tx_shift_q[1];
                    end
                end
                S_PARITY: begin
                    tx_state_q <= S_STOP;
                    tx_line_q  <= 1'b1;
                end
                default: begin
                    tx_state_q <= S_IDLE;
                    tx_line_q  <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchronizer plus previous value for falling-edge detection.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_src_s;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // RX FSM; completion results are registered so they land one edge after the stop sample.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_state_q <= S_IDLE;
            rx_tmr_q   <= 16'd0;
            rx_div_q   <= 16'd0;
            rx_shift_q <= '0;
            rx_char_q  <= '0;
            rx_bit_q   <= 3'd0;
            rx_pon_q   <= 1'b0;
            rx_podd_q  <= 1'b0;
            rx_pbit_q  <= 1'b0;
            rx_push_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            rx_perr_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            if (!ctrl_q[1]) begin
                rx_state_q <= S_IDLE;
            end else if (rx_state_q == S_IDLE) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_q <= S_START;
                    rx_tmr_q   <= rx_half_s;
                    rx_div_q   <= div_eff_s;
                    rx_pon_q   <= ^ctrl_q[3:2];
                    rx_podd_q  <= ctrl_q[3:2] == 2'b01;
                end
            end else if (rx_tmr_q != 16'd0) begin
                rx_tmr_q <= rx_tmr_q - 16'd1;
            end else begin
                rx_tmr_q <= rx_div_q;
                case (rx_state_q)
                    S_START: begin
                        rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                        rx_bit_q   <= 3'd0;
                    end
                    S_DATA: begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == LAST_BIT) rx_state_q <= rx_pon_q ? S_PARITY : S_STOP;
                    end
                    S_PARITY: begin
                        rx_pbit_q  <= rx_s2_q;
                        rx_state_q <= S_STOP;
                    end
                    default: begin
                        rx_state_q <= S_IDLE;
                        if (!rx_s2_q) begin
                            rx_ferr_q <= 1'b1;
                        end else begin
                            rx_push_q <= 1'b1;
                            rx_char_q <= rx_shift_q;
                            rx_perr_q <= rx_pon_q & (rx_pbit_q != par_bit(rx_shift_q, rx_podd_q));
                        end
                    end
                endcase
            end
        end
    end
endmodule
